// File: rtl/uart_tx_param_if.sv
// Host-side word handshake for uart_tx_param: the host drives valid/data,
// the transmitter answers with ready.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB first, optional parity,
// STOP_BITS stop bits, each bit CLKS_PER_BIT clocks. UART_TX_BREAK_EN adds a line-break input.
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
`ifdef UART_TX_BREAK_EN
    input  logic           tx_break,
`endif
    uart_tx_param_if.slave tx_if,
    output logic           tx_out,
    output logic           busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic              PARITY_ODD = (PARITY_MODE == 2);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
            PARITY_MODE < 0 || PARITY_MODE > 2 ||
            (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
            $error("uart_tx_param: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_BREAK_EN
        ,
        BREAK,
        MARK
`endif
    } state_t;

    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;
    logic                 baud_wrap;

    assign baud_wrap      = (baud_cnt == BAUD_LAST);
    assign tx_if.tx_ready = ena && (state == IDLE);

    // Each state holds tx_out for one bit period; the next bit value is loaded on the wrap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
        end else if (!ena) begin
            state    <= IDLE;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (tx_if.tx_valid) begin
                        shift_reg <= tx_if.tx_data;
                        par_bit   <= (^tx_if.tx_data) ^ PARITY_ODD;
                        state     <= START;
                        tx_out    <= 1'b0;
                        busy      <= 1'b1;
                    end
`ifdef UART_TX_BREAK_EN
                    else if (tx_break) begin
                        state  <= BREAK;
                        tx_out <= 1'b0;
                        busy   <= 1'b1;
                    end
`endif
                end
                START: begin
                    if (baud_wrap) begin
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        tx_out    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_MODE != 0) begin
                                state  <= PARITY;
                                tx_out <= par_bit;
                            end else begin
                                state  <= STOP;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            tx_out    <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_out   <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx_out <= 1'b1;
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    baud_cnt <= '0;
                    if (!tx_break) begin
                        state  <= MARK;
                        tx_out <= 1'b1;
                    end else begin
                        tx_out <= 1'b0;
                    end
                end
                MARK: begin
                    tx_out <= 1'b1;
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    tx_out   <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances cover 8N1, even/odd parity and 7-bit/2-stop
// framing at CLKS_PER_BIT=4. Define UART_TX_BREAK_EN to also exercise the break feature.
module tb_uart_tx_param;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    always #5 clk = ~clk;

    logic       valid [4];
    logic [8:0] data  [4];
    logic       ready [4];
    logic       out   [4];
    logic       busy  [4];
`ifdef UART_TX_BREAK_EN
    logic       brk;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    uart_tx_param_if #(.DATA_BITS(8)) if0 ();
    uart_tx_param_if #(.DATA_BITS(8)) if1 ();
    uart_tx_param_if #(.DATA_BITS(8)) if2 ();
    uart_tx_param_if #(.DATA_BITS(7)) if3 ();

    assign if0.tx_valid = valid[0];
    assign if1.tx_valid = valid[1];
    assign if2.tx_valid = valid[2];
    assign if3.tx_valid = valid[3];
    assign if0.tx_data  = data[0][7:0];
    assign if1.tx_data  = data[1][7:0];
    assign if2.tx_data  = data[2][7:0];
    assign if3.tx_data  = data[3][6:0];
    assign ready[0] = if0.tx_ready;
    assign ready[1] = if1.tx_ready;
    assign ready[2] = if2.tx_ready;
    assign ready[3] = if3.tx_ready;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk),
`endif
        .tx_if(if0.slave), .tx_out(out[0]), .busy(busy[0]));

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
`ifdef UART_TX_BREAK_EN
        .tx_break(1'b0),
`endif
        .tx_if(if1.slave), .tx_out(out[1]), .busy(busy[1]));

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
`ifdef UART_TX_BREAK_EN
        .tx_break(1'b0),
`endif
        .tx_if(if2.slave), .tx_out(out[2]), .busy(busy[2]));

    uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
`ifdef UART_TX_BREAK_EN
        .tx_break(1'b0),
`endif
        .tx_if(if3.slave), .tx_out(out[3]), .busy(busy[3]));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents a word at a falling edge; returns at the falling edge right after the accept.
    task automatic applyStimulus(input int idx, input logic [8:0] d);
        @(negedge clk);
        valid[idx] = 1'b1;
        data[idx]  = d;
        #1 checkOutput("ready_before_accept", 32'(ready[idx]), 32'd1);
        @(negedge clk);
        valid[idx] = 1'b0;
        checkOutput("ready_after_accept", 32'(ready[idx]), 32'd0);
    endtask

    // exp[b] is the b-th serial bit (bit 0 = start bit); sampled once per clock.
    task automatic sampleFrame(input int idx, input string tag, input logic [11:0] exp, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < CPB; c++) begin
                checkOutput($sformatf("%s_bit%0d_clk%0d", tag, b, c), 32'(out[idx]), 32'(exp[b]));
                if ((b == 0 && c == 0) || (b == nbits - 1 && c == CPB - 1))
                    checkOutput($sformatf("%s_busy_in_frame", tag), 32'(busy[idx]), 32'd1);
                @(negedge clk);
            end
        end
        checkOutput($sformatf("%s_busy_after", tag), 32'(busy[idx]), 32'd0);
        checkOutput($sformatf("%s_idle_line", tag), 32'(out[idx]), 32'd1);
        checkOutput($sformatf("%s_ready_after", tag), 32'(ready[idx]), 32'd1);
    endtask

    initial begin
        logic [11:0] exp_a5;
        exp_a5 = {2'b00, 1'b1, 8'hA5, 1'b0};
        rst_n = 1'b0;
        ena   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid[i] = 1'b0;
            data[i]  = '0;
        end
`ifdef UART_TX_BREAK_EN
        brk = 1'b0;
`endif
        #12;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("reset_tx_out%0d", i), 32'(out[i]), 32'd1);
            checkOutput($sformatf("reset_busy%0d", i), 32'(busy[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0, 9'h0A5);
        sampleFrame(0, "a5_8n1", exp_a5, 10);

        applyStimulus(1, 9'h0A5);
        sampleFrame(1, "a5_even", {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
        applyStimulus(2, 9'h0A5);
        sampleFrame(2, "a5_odd", {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11);
        applyStimulus(1, 9'h001);
        sampleFrame(1, "01_even", {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11);
        applyStimulus(2, 9'h001);
        sampleFrame(2, "01_odd", {1'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11);

        applyStimulus(3, 9'h07F);
        sampleFrame(3, "7f_7n2", {2'b00, 2'b11, 7'h7F, 1'b0}, 10);

        // Back-to-back: valid stays high, data changes right after the first accept.
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 9'h055;
        @(negedge clk);
        data[0]  = 9'h0AA;
        sampleFrame(0, "b2b_55", {2'b00, 1'b1, 8'h55, 1'b0}, 10);
        @(negedge clk);
        valid[0] = 1'b0;
        checkOutput("b2b_second_accepted", 32'(ready[0]), 32'd0);
        sampleFrame(0, "b2b_aa", {2'b00, 1'b1, 8'hAA, 1'b0}, 10);

        // ena dropped mid-frame, then a clean new frame.
        applyStimulus(0, 9'h0A5);
        for (int k = 1; k <= 12; k++) begin
            checkOutput("ena_pre_drop", 32'(out[0]), 32'(exp_a5[(k - 1) / CPB]));
            @(negedge clk);
        end
        checkOutput("ena_clk13_bit", 32'(out[0]), 32'd1);
        ena = 1'b0;
        #1 checkOutput("ena_low_ready", 32'(ready[0]), 32'd0);
        @(negedge clk);
        checkOutput("ena_drop_tx_out", 32'(out[0]), 32'd1);
        checkOutput("ena_drop_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        checkOutput("ena_low_ready_hold", 32'(ready[0]), 32'd0);
        checkOutput("ena_low_line_hold", 32'(out[0]), 32'd1);
        ena = 1'b1;
        #1 checkOutput("ena_restore_ready", 32'(ready[0]), 32'd1);
        applyStimulus(0, 9'h03C);
        sampleFrame(0, "3c_after_ena", {2'b00, 1'b1, 8'h3C, 1'b0}, 10);

        // Asynchronous reset in the middle of the data bits.
        applyStimulus(0, 9'h0A5);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_tx_out", 32'(out[0]), 32'd1);
        checkOutput("async_rst_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_line", 32'(out[0]), 32'd1);
        checkOutput("post_rst_busy", 32'(busy[0]), 32'd0);
        applyStimulus(0, 9'h0A5);
        sampleFrame(0, "a5_post_rst", exp_a5, 10);

`ifdef UART_TX_BREAK_EN
        @(negedge clk);
        brk = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checkOutput("break_low", 32'(out[0]), 32'd0);
            checkOutput("break_ready", 32'(ready[0]), 32'd0);
            checkOutput("break_busy", 32'(busy[0]), 32'd1);
        end
        brk = 1'b0;
        for (int k = 1; k <= CPB; k++) begin
            @(negedge clk);
            checkOutput("mark_high", 32'(out[0]), 32'd1);
            checkOutput("mark_ready", 32'(ready[0]), 32'd0);
        end
        @(negedge clk);
        checkOutput("break_done_ready", 32'(ready[0]), 32'd1);
        checkOutput("break_done_busy", 32'(busy[0]), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
